// File: rtl/demux1t2_32_buf_if.sv
// demux1t2_32_buf_if: upstream push port and two downstream valid/ready channels
interface demux1t2_32_buf_if;
  logic        s_valid;
  logic        s_ready;
  logic        s_sel;
  logic [31:0] s_data;
  logic        m0_valid;
  logic        m0_ready;
  logic [31:0] m0_data;
  logic        m1_valid;
  logic        m1_ready;
  logic [31:0] m1_data;
  modport slave (
    input  s_valid, s_sel, s_data, m0_ready, m1_ready,
    output s_ready, m0_valid, m0_data, m1_valid, m1_data
  );
  modport master (
    output s_valid, s_sel, s_data, m0_ready, m1_ready,
    input  s_ready, m0_valid, m0_data, m1_valid, m1_data
  );
endinterface

// File: rtl/demux1t2_32_buf.sv
// demux1t2_32_buf: steers 32-bit words into one of two FIFOs, with per-channel accept counters
module demux1t2_32_buf #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  demux1t2_32_buf_if.slave bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  logic [31:0]      mem_q [2][DEPTH];
  logic [31:0]      mem_d [2][DEPTH];
  logic [PW-1:0]    wp_q [2], wp_d [2], rp_q [2], rp_d [2];
  logic [OW-1:0]    occ_q [2], occ_d [2];
  logic [CNT_W-1:0] cnt_q [2], cnt_d [2];
  logic [1:0]       valid_q, valid_d;
  logic [1:0]       full, push, pop;
  assign full = {occ_q[1] == OW'(DEPTH), occ_q[0] == OW'(DEPTH)};
  // s_ready depends only on s_sel and registered occupancy, never on mk_ready
  assign bus.s_ready = !full[bus.s_sel];
  assign push = {2{bus.s_valid}} & ~full & {bus.s_sel, !bus.s_sel};
  assign pop = valid_q & {bus.m1_ready, bus.m0_ready};
  assign bus.m0_valid = valid_q[0];
  assign bus.m1_valid = valid_q[1];
  assign bus.m0_data = valid_q[0] ? mem_q[0][rp_q[0]] : 32'h0;
  assign bus.m1_data = valid_q[1] ? mem_q[1][rp_q[1]] : 32'h0;
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem_d[k][wp_q[k]] = bus.s_data;
      wp_d[k]    = push[k] ? wp_q[k] + PW'(1) : wp_q[k];
      rp_d[k]    = pop[k] ? rp_q[k] + PW'(1) : rp_q[k];
      cnt_d[k]   = push[k] ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
      occ_d[k]   = occ_q[k] + OW'(push[k]) - OW'(pop[k]);
      valid_d[k] = occ_d[k] != '0;
    end
  end
  // storage needs no reset: data outputs are masked to zero while empty
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '{default: '0};
      rp_q    <= '{default: '0};
      occ_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      valid_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_demux1t2_32_buf.sv
// tb_demux1t2_32_buf: scoreboard bench for the buffered 1-to-2 demux (DEPTH=4, CNT_W=4)
module tb_demux1t2_32_buf;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [3:0]  cnt0, cnt1;
  logic [3:0]  ecnt0 = 0, ecnt1 = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] exp_w;
  int          tests = 0, errors = 0, pops1 = 0;
  demux1t2_32_buf_if bus();
  demux1t2_32_buf #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .cnt0(cnt0), .cnt1(cnt1)
  );
  always #5 clk = ~clk;
  // pops are checked before pushes are logged, so a word is never expected in the cycle it is accepted
  always @(negedge clk) if (rst_n) begin
    if (bus.m0_valid && bus.m0_ready) begin
      tests++;
      if (q0.size() == 0) begin errors++; $display("FAIL m0_pop unexpected word %h", bus.m0_data); end
      else begin
        exp_w = q0.pop_front();
        if (bus.m0_data !== exp_w) begin errors++; $display("FAIL m0_data got %h want %h", bus.m0_data, exp_w); end
      end
    end
    if (bus.m1_valid && bus.m1_ready) begin
      tests++;
      pops1++;
      if (q1.size() == 0) begin errors++; $display("FAIL m1_pop unexpected word %h", bus.m1_data); end
      else begin
        exp_w = q1.pop_front();
        if (bus.m1_data !== exp_w) begin errors++; $display("FAIL m1_data got %h want %h", bus.m1_data, exp_w); end
      end
    end
    if (bus.s_valid && bus.s_ready) begin
      if (bus.s_sel) begin q1.push_back(bus.s_data); ecnt1++; end
      else begin q0.push_back(bus.s_data); ecnt0++; end
    end
  end
  task automatic clear_model();
    q0.delete();
    q1.delete();
    ecnt0 = 0;
    ecnt1 = 0;
  endtask
  task automatic push(input logic sel, input logic [31:0] d);
    int n = 0;
    bus.s_valid = 1; bus.s_sel = sel; bus.s_data = d;
    do begin @(negedge clk); n++; end while (!bus.s_ready && n < 50);
    if (!bus.s_ready) begin tests++; errors++; $display("FAIL push_timeout got s_ready=0 want 1"); end
    @(posedge clk); #1;
    bus.s_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    bus.m0_ready = 1; bus.m1_ready = 1;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin errors++; $display("FAIL drain got %0d/%0d left want 0/0", q0.size(), q1.size()); end
  endtask
  task automatic check_cnt(input string name);
    tests++;
    if (cnt0 !== ecnt0 || cnt1 !== ecnt1) begin
      errors++; $display("FAIL %s cnt got %0d/%0d want %0d/%0d", name, cnt0, cnt1, ecnt0, ecnt1);
    end
  endtask
  task automatic hard_reset();
    rst_n = 0; clear_model();
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic test_reset();
    bus.m0_ready = 0; bus.m1_ready = 0;
    for (int i = 0; i < 3; i++) push(0, 32'hDEAD_0000 + i);
    @(posedge clk); #2;
    rst_n = 0; clear_model();
    #1;
    tests++;
    if (bus.m0_valid !== 0 || bus.m1_valid !== 0) begin errors++; $display("FAIL reset_valid got %b%b want 00", bus.m0_valid, bus.m1_valid); end
    tests++;
    if (cnt0 !== 0 || cnt1 !== 0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt0, cnt1); end
    tests++;
    if (bus.m0_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.m0_data); end
    @(posedge clk); #1;
    rst_n = 1;
    push(0, 32'hA5A5_0001);
    tests++;
    if (bus.m0_valid !== 1 || bus.m0_data !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_first got %b/%h want 1/a5a50001", bus.m0_valid, bus.m0_data); end
    check_cnt("reset_first");
    drain();
  endtask
  task automatic test_steering();
    bus.m0_ready = 1; bus.m1_ready = 1;
    push(0, 32'h1111_1111);
    tests++;
    if (bus.m0_valid !== 1 || bus.m0_data !== 32'h1111_1111 || bus.m1_valid !== 0) begin
      errors++; $display("FAIL steer0 got %b/%h m1v=%b want 1/11111111 m1v=0", bus.m0_valid, bus.m0_data, bus.m1_valid);
    end
    push(1, 32'h2222_2222);
    tests++;
    if (bus.m1_valid !== 1 || bus.m1_data !== 32'h2222_2222) begin errors++; $display("FAIL steer1 got %b/%h want 1/22222222", bus.m1_valid, bus.m1_data); end
    check_cnt("steer");
    drain();
  endtask
  task automatic test_full();
    bus.m0_ready = 0;
    for (int i = 0; i < 4; i++) push(0, 32'hF000_0000 + i);
    check_cnt("full_cnt");
    bus.s_valid = 1; bus.s_sel = 0; bus.s_data = 32'hF000_0004;
    #1;
    tests++;
    if (bus.s_ready !== 0) begin errors++; $display("FAIL full_ready0 got %b want 0", bus.s_ready); end
    bus.s_sel = 1; bus.s_data = 32'hC1C1_0001;
    #1;
    tests++;
    if (bus.s_ready !== 1) begin errors++; $display("FAIL full_ready1 got %b want 1", bus.s_ready); end
    @(posedge clk); #1;
    bus.s_valid = 0;
    tests++;
    if (bus.m1_valid !== 1 || bus.m1_data !== 32'hC1C1_0001) begin errors++; $display("FAIL full_ch1 got %b/%h want 1/c1c10001", bus.m1_valid, bus.m1_data); end
    check_cnt("full_ch1_cnt");
  endtask
  task automatic test_full_pop();
    bus.s_valid = 1; bus.s_sel = 0; bus.s_data = 32'hF000_0004; bus.m0_ready = 1;
    #1;
    tests++;
    if (bus.s_ready !== 0) begin errors++; $display("FAIL fullpop_refuse got %b want 0", bus.s_ready); end
    @(posedge clk); #1;
    bus.m0_ready = 0;
    tests++;
    if (bus.s_ready !== 1 || bus.m0_data !== 32'hF000_0001) begin errors++; $display("FAIL fullpop_occ3 got %b/%h want 1/f0000001", bus.s_ready, bus.m0_data); end
    @(posedge clk); #1;
    bus.s_valid = 0;
    tests++;
    if (bus.s_ready !== 0) begin errors++; $display("FAIL fullpop_refull got %b want 0", bus.s_ready); end
    check_cnt("fullpop_cnt");
    drain();
  endtask
  task automatic test_wrap();
    pops1 = 0;
    fork
      for (int i = 0; i < 10; i++) push(1, 32'(i));
      repeat (60) begin @(posedge clk); #1; bus.m1_ready = 1'($urandom_range(0, 1)); end
    join
    drain();
    tests++;
    if (pops1 !== 10) begin errors++; $display("FAIL wrap_count got %0d want 10", pops1); end
    check_cnt("wrap_cnt");
  endtask
  task automatic test_cnt_wrap();
    hard_reset();
    bus.m0_ready = 1;
    for (int i = 0; i < 17; i++) push(0, 32'h7700_0000 + i);
    tests++;
    if (cnt0 !== 4'd1) begin errors++; $display("FAIL cnt_wrap got %0d want 1", cnt0); end
    drain();
  endtask
  initial begin
    bus.s_valid = 0; bus.s_sel = 0; bus.s_data = 0; bus.m0_ready = 0; bus.m1_ready = 0;
    #12 hard_reset();
    test_reset();
    test_steering();
    test_full();
    test_full_pop();
    test_wrap();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/demux1t2_32_buf.md
Name: demux1t2_32_buf

Overview:
- Registered, buffered 1-to-2 demultiplexer for 32-bit words.
- A single upstream producer, such as the CPU write path or the ALU result bus, presents a word with a select bit. The block steers the word into one of two per-channel FIFOs.
- Each FIFO drains to its own downstream consumer through a valid/ready handshake. Typical consumers are the VGA/graphics write port and the peripheral/IO port.
- Per-channel accepted-word counters are provided for debug display on the seven-segment LEDs.

Parameters:
- DEPTH, 4, entries per channel FIFO; must be a power of two and at least 2.
- CNT_W, 16, width of each per-channel word counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block can accept the word on the channel selected by s_sel.
- s_sel  input  1  0 routes to channel 0, 1 routes to channel 1.
- s_data  input  32  upstream word.
- m0_valid  output  1  channel 0 FIFO non-empty.
- m0_ready  input  1  channel 0 consumer takes the head word.
- m0_data  output  32  channel 0 head word.
- m1_valid  output  1  channel 1 FIFO non-empty.
- m1_ready  input  1  channel 1 consumer takes the head word.
- m1_data  output  32  channel 1 head word.
- cnt0  output  CNT_W  words accepted into channel 0 since reset.
- cnt1  output  CNT_W  words accepted into channel 1 since reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears both FIFOs: read pointer, write pointer and occupancy all go to 0.
  - Forces m0_valid=0, m1_valid=0, cnt0=0, cnt1=0.
  - m0_data and m1_data read 32'h0 while their FIFO is empty.
  - Reset asserted mid-transfer discards all buffered words with no partial output.
  - Deassertion takes effect at the next rising edge.
- s_ready:
  - Equals !full of the channel selected by s_sel.
  - It is combinational from s_sel and registered occupancy only.
  - There is no combinational path from m0_ready or m1_ready to s_ready.
- Push:
  - Occurs when s_valid && s_ready.
  - s_data is written to the selected FIFO at its write pointer; the pointer increments modulo DEPTH.
  - The selected counter increments and wraps from 2^CNT_W-1 to 0.
  - If s_valid is high while s_ready is low, nothing is stored and no counter changes. Upstream must hold s_valid, s_sel and s_data stable until accepted.
- Pop on channel k:
  - Occurs when mk_valid && mk_ready. The read pointer increments modulo DEPTH.
  - mk_data always shows the entry at the read pointer, read combinationally from registered storage.
- Latency: a word accepted at edge N is visible on mk_valid/mk_data after edge N, i.e. in cycle N+1. With an empty FIFO and mk_ready held high, there is one word per cycle throughput.
- Push and pop in the same cycle, same channel:
  - Occupancy is unchanged and both pointers advance.
  - When the FIFO is full, the push is refused because s_ready is 0, even if a pop occurs that cycle. The occupancy after that edge is DEPTH-1.
- Pop on one channel with push on the other: fully independent, no interaction.
- Occupancy per channel:
  - Range 0..DEPTH, held in a clog2(DEPTH)+1-bit counter.
  - full = (occ==DEPTH); empty = (occ==0).
  - Pointers wrap at DEPTH without any bubble.
- Ordering: order is preserved per channel. There are no ordering guarantees between channels.
- mk_ready asserted while mk_valid=0 has no effect.
- No combinational loops; all outputs except s_ready and mk_data are direct register outputs.

Test Plan:
- Reset values:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle after pushing 3 words to ch0.
  - Required: m0_valid and m1_valid drop to 0 immediately; cnt0=cnt1=0.
  - Required after release: first push of 32'hA5A5_0001 to ch0 appears on m0_data in the next cycle.
- Steering and latency:
  - Stimulus: push 32'h1111_1111 with sel=0, then 32'h2222_2222 with sel=1, both consumers ready.
  - Required: m0 outputs 11111111 one cycle after its accept, m1 outputs 22222222 one cycle after its accept; cnt0=1, cnt1=1.
- Full boundary:
  - Stimulus: m0_ready=0; push 5 words with sel=0 (DEPTH=4).
  - Required: the first 4 are accepted; s_ready is 0 on the 5th attempt; cnt0=4.
  - Required while s_sel=1 during that stall: s_ready=1, and a ch1 push is accepted.
- Full with simultaneous pop:
  - Stimulus: ch0 full, m0_ready=1 and s_valid=1 with sel=0 in the same cycle.
  - Required: pop occurs, push refused, occupancy 3; the push is accepted in the following cycle.
- Wrap-around:
  - Stimulus: stream 10 words 0..9 to ch1 with random m1_ready backpressure.
  - Required: m1 delivers 0..9 in order with no loss or duplication; cnt1=10.
- Counter wrap (CNT_W=4):
  - Stimulus: accept 17 words on ch0.
  - Required: cnt0 reads 1.
